// File: rtl/bus_ram_responder.sv
// Word-addressed single-port RAM on the responder side of the data bus, with programmable
// read/write wait states. Optional per-byte write enables: define BUS_RAM_BYTE_LANE_EN.
module bus_ram_responder #(
    parameter int ADDR_BITS  = 12,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] busaddr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
`ifdef BUS_RAM_BYTE_LANE_EN
    input  logic [3:0]  wr_be,
`endif
    output logic        rw_wait,
    output logic [31:0] rd_data,
    output logic        proto_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } kind_t;

    logic [31:0]          mem [DEPTH];
    logic [3:0]           cnt;
    logic [3:0]           eff_cnt;
    logic [3:0]           cnt_next;
    logic [3:0]           lat;
    logic [ADDR_BITS-1:0] index;
    logic [ADDR_BITS-1:0] lat_index;
    kind_t                kind;
    kind_t                lat_kind;
    logic                 req;
    logic                 same_txn;
    logic                 stalled;
    logic                 commit;
    logic [3:0]           lane_en;
    logic                 unused_addr_bits;

    assign index            = busaddr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{busaddr[31:ADDR_BITS+2], busaddr[1:0]};
    assign req              = rd_req | wr_req;
    assign kind             = rd_req ? KIND_READ : KIND_WRITE;

`ifdef BUS_RAM_BYTE_LANE_EN
    assign lane_en = wr_be;
`else
    assign lane_en = 4'b1111;
`endif

    // A request whose kind or word differs from the latched one starts over from zero.
    always_comb begin
        same_txn = 1'b0;
        eff_cnt  = 4'd0;
        lat      = 4'd0;
        stalled  = 1'b0;
        rw_wait  = 1'b0;
        commit   = 1'b0;
        cnt_next = 4'd0;

        same_txn = (cnt != 4'd0) && (kind == lat_kind) && (index == lat_index);
        eff_cnt  = same_txn ? cnt : 4'd0;
        lat      = (kind == KIND_READ) ? 4'(RD_LATENCY) : 4'(WR_LATENCY);
        stalled  = req && (eff_cnt < lat);
        rw_wait  = stalled && !rst;
        commit   = !rst && wr_req && !rd_req && !stalled;
        if (!rst && stalled) begin
            cnt_next = eff_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_index <= '0;
            lat_kind  <= KIND_READ;
            rd_data   <= 32'd0;
            proto_err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (req) begin
                lat_index <= index;
                lat_kind  <= kind;
            end
            if (rd_req) begin
                rd_data <= mem[index];
            end
            if (rd_req && wr_req) begin
                proto_err <= 1'b1;
            end
        end
    end

    // The array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[index][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Randomized self-checking bench for bus_ram_responder against an array-based memory model.
// Also exercises a second instance with zero write latency and minimum read latency.
module tb_bus_ram_responder;

    localparam int RD = 2;
    localparam int WR = 1;

    logic        clk;
    logic        rst;
    logic [31:0] busaddr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rw_wait;
    logic [31:0] rd_data;
    logic        proto_err;

    logic [31:0] z_busaddr;
    logic        z_rd_req;
    logic        z_wr_req;
    logic [31:0] z_wr_data;
    logic [3:0]  z_wr_be;
    logic        z_rw_wait;
    logic [31:0] z_rd_data;
    logic        z_proto_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [4096];

    bus_ram_responder #(.ADDR_BITS(12), .RD_LATENCY(RD), .WR_LATENCY(WR)) dut (
        .clk(clk), .rst(rst), .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_data(wr_data),
`ifdef BUS_RAM_BYTE_LANE_EN
        .wr_be(wr_be),
`endif
        .rw_wait(rw_wait), .rd_data(rd_data), .proto_err(proto_err)
    );

    bus_ram_responder #(.ADDR_BITS(12), .RD_LATENCY(1), .WR_LATENCY(0)) dut_z (
        .clk(clk), .rst(rst), .busaddr(z_busaddr), .rd_req(z_rd_req), .wr_req(z_wr_req),
        .wr_data(z_wr_data),
`ifdef BUS_RAM_BYTE_LANE_EN
        .wr_be(z_wr_be),
`endif
        .rw_wait(z_rw_wait), .rd_data(z_rd_data), .proto_err(z_proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic idle();
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Holds a request until rw_wait drops (bounded); leaves the request asserted.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          output int waits, output logic [31:0] rdata);
        bit done;
        busaddr = addr;
        rd_req  = rd;
        wr_req  = wr;
        wr_data = data;
        wr_be   = be;
        waits   = 0;
        rdata   = 32'hx;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (rw_wait === 1'b0) begin
                rdata = rd_data;
                done  = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        if (done && wr && !rd) model_mem[addr[13:2]] = merge(model_mem[addr[13:2]], data, be);
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; busaddr = 32'h10;
        z_rd_req = 1'b1; z_busaddr = 32'h10;
        @(negedge clk);
        checks++; if (rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw_wait got %b expected 0", rw_wait); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_data got %h expected 0", rd_data); end
        checks++; if (z_rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset_z_rw_wait got %b expected 0", z_rw_wait); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got %b expected 0", proto_err); end
        checks++; if (z_proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_z_proto_err got %b expected 0", z_proto_err); end
        @(posedge clk); #1;
        rst = 1'b0; z_rd_req = 1'b0;
        idle();
    endtask

    task automatic test_basic_read();
        int w; logic [31:0] d;
        do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w, d);
        checks++; if (w !== WR) begin errors++; $display("[TB] FAIL basic_write_waits got %0d expected %0d", w, WR); end
        idle();
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, w, d);
        checks++; if (w !== RD) begin errors++; $display("[TB] FAIL basic_read_waits got %0d expected %0d", w, RD); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_read_data got %h expected deadbeef", d); end
        idle();
    endtask

    task automatic test_write_commit();
        int w; logic [31:0] d;
        do_txn(1'b0, 1'b1, 32'h20, 32'h01234567, 4'hF, w, d);
        idle();
        busaddr = 32'h20; wr_req = 1'b1; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        @(negedge clk);
        checks++; if (rw_wait !== 1'b1) begin errors++; $display("[TB] FAIL withdraw_stall got %b expected 1", rw_wait); end
        @(posedge clk); #1;
        idle();
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, w, d);
        checks++; if (d !== 32'h01234567) begin errors++; $display("[TB] FAIL withdraw_no_commit got %h expected 01234567", d); end
        idle();
        do_txn(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, w, d);
        checks++; if (w !== WR) begin errors++; $display("[TB] FAIL write_waits got %0d expected %0d", w, WR); end
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, w, d);
        checks++; if (w !== RD) begin errors++; $display("[TB] FAIL b2b_read_waits got %0d expected %0d", w, RD); end
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_read_data got %h expected cafef00d", d); end
        idle();
    endtask

    task automatic test_restart();
        int w; logic [31:0] d; logic exp_wait;
        do_txn(1'b0, 1'b1, 32'h30, $urandom(), 4'hF, w, d);
        do_txn(1'b0, 1'b1, 32'h34, $urandom(), 4'hF, w, d);
        idle();
        busaddr = 32'h30; rd_req = 1'b1;
        @(negedge clk);
        checks++; if (rw_wait !== 1'b1) begin errors++; $display("[TB] FAIL restart_first got %b expected 1", rw_wait); end
        @(posedge clk); #1;
        busaddr = 32'h34;
        for (int c = 0; c <= RD; c++) begin
            exp_wait = (c < RD);
            @(negedge clk);
            checks++; if (rw_wait !== exp_wait) begin errors++; $display("[TB] FAIL restart_wait_c%0d got %b expected %b", c, rw_wait, exp_wait); end
            if (!exp_wait) begin
                checks++; if (rd_data !== model_mem[13]) begin errors++; $display("[TB] FAIL restart_data got %h expected %h", rd_data, model_mem[13]); end
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_zero_latency();
        logic [31:0] v1, v2;
        v1 = $urandom(); v2 = $urandom();
        z_wr_be = 4'hF;
        z_busaddr = 32'h24; z_wr_data = v1; z_wr_req = 1'b1;
        @(negedge clk);
        checks++; if (z_rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL zero_lat_wait1 got %b expected 0", z_rw_wait); end
        @(posedge clk); #1;
        z_busaddr = 32'h28; z_wr_data = v2;
        @(negedge clk);
        checks++; if (z_rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL zero_lat_wait2 got %b expected 0", z_rw_wait); end
        @(posedge clk); #1;
        z_wr_req = 1'b0; z_rd_req = 1'b1; z_busaddr = 32'h24;
        @(negedge clk);
        checks++; if (z_rw_wait !== 1'b1) begin errors++; $display("[TB] FAIL zero_lat_rd_stall got %b expected 1", z_rw_wait); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (z_rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL zero_lat_rd_done got %b expected 0", z_rw_wait); end
        checks++; if (z_rd_data !== v1) begin errors++; $display("[TB] FAIL zero_lat_data1 got %h expected %h", z_rd_data, v1); end
        @(posedge clk); #1;
        z_busaddr = 32'h28;
        @(negedge clk);
        checks++; if (z_rw_wait !== 1'b1) begin errors++; $display("[TB] FAIL zero_lat_b2b_stall got %b expected 1", z_rw_wait); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (z_rd_data !== v2) begin errors++; $display("[TB] FAIL zero_lat_data2 got %h expected %h", z_rd_data, v2); end
        @(posedge clk); #1;
        z_rd_req = 1'b0;
    endtask

    task automatic test_byte_lanes();
        int w; logic [31:0] d; logic [31:0] exp_d;
        do_txn(1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, w, d);
        idle();
`ifdef BUS_RAM_BYTE_LANE_EN
        do_txn(1'b0, 1'b1, 32'h0, 32'hAAAAAAAA, 4'b0100, w, d);
        exp_d = 32'h11AA3344;
        idle();
        do_txn(1'b0, 1'b1, 32'h0, 32'h55555555, 4'b0000, w, d);
        checks++; if (w !== WR) begin errors++; $display("[TB] FAIL be_zero_waits got %0d expected %0d", w, WR); end
`else
        do_txn(1'b0, 1'b1, 32'h0, 32'hAAAAAAAA, 4'hF, w, d);
        exp_d = 32'hAAAAAAAA;
`endif
        idle();
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, w, d);
        checks++; if (d !== exp_d) begin errors++; $display("[TB] FAIL byte_lane_data got %h expected %h", d, exp_d); end
        idle();
    endtask

    task automatic test_proto_err();
        int w; logic [31:0] d; logic [31:0] old_w;
        old_w = $urandom();
        do_txn(1'b0, 1'b1, 32'h40, old_w, 4'hF, w, d);
        idle();
        do_txn(1'b1, 1'b1, 32'h40, ~old_w, 4'hF, w, d);
        checks++; if (w !== RD) begin errors++; $display("[TB] FAIL both_waits got %0d expected %0d", w, RD); end
        checks++; if (d !== old_w) begin errors++; $display("[TB] FAIL both_data got %h expected %h", d, old_w); end
        idle(); idle(); idle();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_err_sticky got %b expected 1", proto_err); end
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, w, d);
        checks++; if (d !== old_w) begin errors++; $display("[TB] FAIL both_no_write got %h expected %h", d, old_w); end
        idle();
        busaddr = 32'h10; rd_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rw_wait !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wait got %b expected 0", rw_wait); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL midrst_rd_data got %h expected 0", rd_data); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_proto_err got %b expected 0", proto_err); end
        checks++; if (rw_wait !== 1'b1) begin errors++; $display("[TB] FAIL midrst_restart got %b expected 1", rw_wait); end
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, w, d);
        checks++; if (w !== RD - 1) begin errors++; $display("[TB] FAIL midrst_waits got %0d expected %0d", w, RD - 1); end
        checks++; if (d !== model_mem[4]) begin errors++; $display("[TB] FAIL midrst_mem_intact got %h expected %h", d, model_mem[4]); end
        idle();
    endtask

    task automatic test_random();
        logic [11:0] pool [16];
        int w, sel, exp_w; logic [31:0] d, addr, exp_d; logic rd, wr; logic [3:0] be;
        for (int i = 0; i < 16; i++) begin
            pool[i] = 12'($urandom_range(64, 4095));
            do_txn(1'b0, 1'b1, {18'd0, pool[i], 2'b00}, $urandom(), 4'hF, w, d);
        end
        idle();
        for (int n = 0; n < 150; n++) begin
            addr = ($urandom() & 32'hFFFF_C000) | (32'(pool[$urandom_range(0, 15)]) << 2)
                   | 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            rd = (sel < 4) || (sel == 9);
            wr = (sel >= 4);
`ifdef BUS_RAM_BYTE_LANE_EN
            be = 4'($urandom());
`else
            be = 4'hF;
`endif
            exp_w = rd ? RD : WR;
            exp_d = model_mem[addr[13:2]];
            do_txn(rd, wr, addr, $urandom(), be, w, d);
            checks++; if (w !== exp_w) begin errors++; $display("[TB] FAIL rand_waits_%0d got %0d expected %0d", n, w, exp_w); end
            if (rd) begin
                checks++; if (d !== exp_d) begin errors++; $display("[TB] FAIL rand_data_%0d got %h expected %h", n, d, exp_d); end
            end
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1; busaddr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0; wr_be = 4'hF;
        z_busaddr = '0; z_rd_req = 1'b0; z_wr_req = 1'b0; z_wr_data = '0; z_wr_be = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_read();
        test_write_commit();
        test_restart();
        test_zero_latency();
        test_byte_lanes();
        test_proto_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Word-addressed single-port RAM that sits on the responder (target) side of the core's data bus (busaddr / rd_req / wr_req / rw_wait / wr_data / rd_data).
- Answers load/store requests from the Memory pipeline stage.
- Inserts a programmable number of wait states through rw_wait, so stall paths in the pipeline can be exercised and modelled.

Parameters:
ADDR_BITS, 12, number of word-address bits; array depth is 2**ADDR_BITS 32-bit words
RD_LATENCY, 2, cycles of rw_wait inserted per read; legal range 1..15
WR_LATENCY, 1, cycles of rw_wait inserted per write; legal range 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
busaddr  input  32  byte address; bits [1:0] ignored, word index = busaddr[ADDR_BITS+1:2], upper bits ignored (aliasing)
rd_req  input  1  read request, level, held by initiator until rw_wait low
wr_req  input  1  write request, level, held by initiator until rw_wait low
wr_data  input  32  store data, sampled at commit edge
rw_wait  output  1  combinational stall; high while the presented request is not yet complete
rd_data  output  32  registered read data; valid in the completion cycle of a read
proto_err  output  1  sticky flag: rd_req and wr_req were seen high together

Behaviour:
- Reset (rst high at an edge):
  - Txn counter cnt <= 0; latched address/kind cleared; rd_data <= 0; proto_err <= 0.
  - RAM contents are not cleared and are preserved across reset.
  - rw_wait is forced 0 during any cycle with rst high; no write commits in that cycle.
- Transaction:
  - Defined by kind (read/write) plus word index.
  - First cycle N = first cycle the request is seen with cnt==0, or any cycle where kind/index differ from the latched values.
  - A mismatch restarts counting: effective cnt = 0 that cycle. Mid-transaction address changes are legal and simply restart.
- L = RD_LATENCY for reads, WR_LATENCY for writes.
  - rw_wait = 1 in cycles N..N+L-1; 0 in completion cycle N+L.
  - cnt increments each stalled cycle and returns to 0 at the edge ending the completion cycle.
- Back-to-back requests: a request still held in N+L+1 is a new transaction (new full latency).
- Reads:
  - rd_data <= mem[index] on every edge where rd_req is high.
  - The value in cycle N+L is therefore the word at the edge ending N+L-1.
  - rd_data holds its value when rd_req is low.
  - A write committing in the same cycle as a read of the same word is not visible to that read.
- Writes:
  - mem[index] <= wr_data at the edge ending the completion cycle only.
  - No commit when the request is withdrawn or changed earlier.
  - WR_LATENCY=0: rw_wait never asserted for writes; commit at end of cycle N.
- Both rd_req and wr_req high:
  - Served as a read; write suppressed.
  - proto_err <= 1 and stays 1 until reset.
- No request: rw_wait = 0; cnt <= 0; no array access side effects.
- Initiator withdraws request before completion: cnt <= 0 next edge, nothing committed.

Optional Feature:
BUS_RAM_BYTE_LANE_EN
- Defined:
  - Adds input wr_be[3:0] (one bit per byte lane, bit i = wr_data[8i+7:8i]).
  - At commit, only lanes with wr_be[i]=1 are written; wr_be=4'b0000 commits nothing but still completes with normal latency.
- Undefined:
  - Port absent; every write commits all 32 bits, including replicated byte-store data.

Test Plan:
- Reset, then read at 0x10 with RD_LATENCY=2, mem[4]=0xDEADBEEF -> rw_wait 1,1,0; rd_data=0xDEADBEEF in 3rd cycle.
- Write 0xCAFEF00D to 0x20 with WR_LATENCY=1, then read 0x20 -> write stalls 1 cycle; read returns 0xCAFEF00D; cycle before commit, mem[8] still old value.
- WR_LATENCY=0 write to 0x24 -> rw_wait never high; committed after 1 edge.
- Read 0x30 held, busaddr switched to 0x34 after 1 stall cycle -> counter restarts; rw_wait high 2 more cycles; rd_data = mem[13].
- rd_req and wr_req high together at 0x40 -> read returns old mem[16]; no write; proto_err=1 held until rst; rst mid-read -> rw_wait 0, rd_data 0, cnt 0; memory intact.
- (BUS_RAM_BYTE_LANE_EN) mem[0]=0x11223344, write 0xAAAAAAAA, wr_be=4'b0100 -> mem[0]=0x11AA3344.
